// File: rtl/ppm_cpa_serial.sv
// Digit-serial carry-propagate adder closing the partial-product multiplier:
// sums the compressor tree's sum and carry rows CHUNK bits per cycle.
module ppm_cpa_serial #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout
);
    localparam int K  = WIDTH / CHUNK;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_s, op_c, res_q, res_nxt;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [31:0]      sh;
    logic [CHUNK-1:0] csum;
    logic             cout_c;
    logic             last;

    assign sh   = 32'(idx) * 32'(CHUNK);
    assign last = (idx == IW'(K - 1));

    // One CHUNK-bit adder; shifts select the active slice so K = 1 needs no special case.
    always_comb begin
        {cout_c, csum} = {1'b0, CHUNK'(op_s >> sh)} + {1'b0, CHUNK'(op_c >> sh)}
                       + {{CHUNK{1'b0}}, carry};
        res_nxt = (res_q & ~(CMASK << sh)) | (WIDTH'(csum) << sh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_cout   <= 1'b0;
            idx        <= '0;
            carry      <= 1'b0;
            op_s       <= '0;
            op_c       <= '0;
            res_q      <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    op_s     <= in_sum;
                    op_c     <= in_carry;
                    idx      <= '0;
                    carry    <= 1'b0;
                    in_ready <= 1'b0;
                    state    <= ADD;
                end
                ADD: begin
                    res_q <= res_nxt;
                    carry <= cout_c;
                    idx   <= idx + 1'b1;
                    // Outputs update only here, so they hold through the next operation.
                    if (last) begin
                        out_result <= res_nxt;
                        out_cout   <= cout_c;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
